// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU. Requesters are granted
// round-robin, the winning operation is held on the ALU inputs for the
// required number of cycles, and the result is returned with the owner id.
module alu_arbiter #(
  parameter int MULDIV_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_data1,
  input  logic [31:0] req0_data2,
  input  logic [5:0]  req0_op,
  input  logic [31:0] req1_data1,
  input  logic [31:0] req1_data2,
  input  logic [5:0]  req1_op,
  output logic [31:0] alu_data1,
  output logic [31:0] alu_data2,
  output logic [5:0]  alu_operation,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        resp_zero,
  output logic        resp_err,
  output logic        busy
);

  localparam logic [5:0] OP_MUL = 6'b001001;
  localparam logic [5:0] OP_DIV = 6'b001010;
  localparam logic [5:0] OP_MOD = 6'b001011;

  // Counter must hold MULDIV_WAIT; keep at least one bit for MULDIV_WAIT = 0.
  localparam int CW = (MULDIV_WAIT < 1) ? 1 : $clog2(MULDIV_WAIT + 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic          rr;
  logic [CW-1:0] count;
  logic          owner;

  logic          grant;
  logic          grant_id;
  logic [31:0]   sel_data1;
  logic [31:0]   sel_data2;
  logic [5:0]    sel_op;
  logic          sel_muldiv;
  logic          sel_divzero;
  logic          lat_divzero;

  // Round-robin pick among valid requesters; only meaningful in IDLE.
  always_comb begin
    grant    = (state == IDLE) && (req0_valid || req1_valid);
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = rr;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  // Ready is gated by rst_n so it is low for the whole reset assertion.
  assign req0_ready = rst_n & grant & ~grant_id;
  assign req1_ready = rst_n & grant &  grant_id;

  assign sel_data1   = grant_id ? req1_data1 : req0_data1;
  assign sel_data2   = grant_id ? req1_data2 : req0_data2;
  assign sel_op      = grant_id ? req1_op    : req0_op;
  assign sel_muldiv  = (sel_op == OP_MUL) || (sel_op == OP_DIV) || (sel_op == OP_MOD);
  assign sel_divzero = ((sel_op == OP_DIV) || (sel_op == OP_MOD)) && (sel_data2 == 32'd0);

  // Division by zero is decided from the latched operands, not the live inputs.
  assign lat_divzero = ((alu_operation == OP_DIV) || (alu_operation == OP_MOD)) &&
                       (alu_data2 == 32'd0);

  assign busy       = (state != IDLE);
  assign resp_valid = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one grant per IDLE visit, leave EXEC when the wait expires,
  // leave DONE only when the consumer takes the response.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (count == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, arbitration pointer and wait counter, loaded on grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_data1     <= '0;
      alu_data2     <= '0;
      alu_operation <= '0;
      owner         <= 1'b0;
      rr            <= 1'b0;
      count         <= '0;
    end else if (state == IDLE) begin
      if (grant) begin
        alu_data1     <= sel_data1;
        alu_data2     <= sel_data2;
        alu_operation <= sel_op;
        owner         <= grant_id;
        rr            <= ~grant_id;
        count         <= (sel_muldiv && !sel_divzero) ? CW'(MULDIV_WAIT) : '0;
      end
    end else if (state == EXEC) begin
      if (count != '0) begin
        count <= count - CW'(1);
      end
    end
  end

  // Response capture at the end of EXEC; held unchanged through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
    end else if ((state == EXEC) && (count == '0)) begin
      resp_id <= owner;
      if (lat_divzero) begin
        resp_result <= 32'hFFFF_FFFF;
        resp_zero   <= 1'b0;
        resp_err    <= 1'b1;
      end else begin
        resp_result <= alu_result;
        resp_zero   <= alu_zero;
        resp_err    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes hand-computed expected
// responses; a negedge monitor checks latency, stability and response content.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_data1, req0_data2, req1_data1, req1_data2;
  logic [5:0]  req0_op, req1_op;
  logic [31:0] alu_data1, alu_data2;
  logic [5:0]  alu_operation;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        resp_valid, resp_ready, resp_id, resp_zero, resp_err, busy;
  logic [31:0] resp_result;

  alu_arbiter #(.MULDIV_WAIT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_data1(req0_data1), .req0_data2(req0_data2), .req0_op(req0_op),
    .req1_data1(req1_data1), .req1_data2(req1_data2), .req1_op(req1_op),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared ALU model driven by the arbiter's ALU outputs.
  logic [31:0] m;
  always_comb begin
    m = 32'd0;
    case (alu_operation)
      6'b000001: m = alu_data1 + alu_data2;
      6'b000010: m = alu_data1 - alu_data2;
      6'b001001: m = alu_data1 * alu_data2;
      6'b001010: m = (alu_data2 == 32'd0) ? 32'd0 : alu_data1 / alu_data2;
      6'b001011: m = (alu_data2 == 32'd0) ? 32'd0 : alu_data1 % alu_data2;
      default:   m = alu_data1 ^ alu_data2;
    endcase
    alu_result = m;
    alu_zero   = (m == 32'd0);
  end

  typedef struct {
    logic        id;
    logic [31:0] result;
    logic        zero;
    logic        err;
    int          lat;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int grants = 0;
  int resps  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input logic id, input logic [31:0] r, input logic z, input logic e, input int lat);
    exp_t x;
    x.id = id; x.result = r; x.zero = z; x.err = e; x.lat = lat;
    q.push_back(x);
  endtask

  // Monitor: grants, latency, hold-stability and response content.
  int          cyc = 0;
  int          grant_cyc = 0;
  logic        held = 1'b0;
  logic [34:0] held_val;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (req0_ready || req1_ready) begin
        chk("ready_onehot_idle", {req0_ready & req1_ready, busy}, 64'd0);
        grant_cyc = cyc;
        grants++;
      end
      if (resp_valid) begin
        if (!held) begin
          if (q.size() == 0) begin
            chk("unexpected_resp", 64'd1, 64'd0);
          end else begin
            chk("latency", 64'(cyc - grant_cyc), 64'(q[0].lat));
          end
        end else begin
          chk("resp_stable", {29'd0, resp_id, resp_result, resp_zero, resp_err}, {29'd0, held_val});
        end
        held_val = {resp_id, resp_result, resp_zero, resp_err};
        if (resp_ready) begin
          if (q.size() != 0) begin
            exp_t x;
            x = q.pop_front();
            chk("resp_id", 64'(resp_id), 64'(x.id));
            chk("resp_result", 64'(resp_result), 64'(x.result));
            chk("resp_zero_err", {62'd0, resp_zero, resp_err}, {62'd0, x.zero, x.err});
          end
          resps++;
          held = 1'b0;
        end else begin
          held = 1'b1;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    chk(name, {req0_ready, req1_ready, resp_valid, resp_id, resp_zero, resp_err, busy,
               |alu_data1, |alu_data2, |alu_operation, |resp_result}, 64'd0);
  endtask

  // Raise the requesters in mask, drop them after n grants, wait for n responses.
  task automatic go(input logic [1:0] mask, input int n);
    int g0, r0, k;
    g0 = grants; r0 = resps;
    req0_valid = mask[0];
    req1_valid = mask[1];
    k = 0;
    while (grants < g0 + n && k < 200) begin @(posedge clk); #1; k++; end
    if (grants < g0 + n) chk("grant_timeout", 64'(grants - g0), 64'(n));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data1 = 32'hDEAD; req0_data2 = 32'hBEEF; req0_op = 6'b000010;
    req1_data1 = 32'hDEAD; req1_data2 = 32'hBEEF; req1_op = 6'b000010;
    k = 0;
    while (resps < r0 + n && k < 200) begin @(posedge clk); #1; k++; end
    if (resps < r0 + n) chk("resp_timeout", 64'(resps - r0), 64'(n));
  endtask

  task automatic set0(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    req0_op = op; req0_data1 = a; req0_data2 = b;
  endtask

  task automatic set1(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    req1_op = op; req1_data1 = a; req1_data2 = b;
  endtask

  initial begin
    int k, r0;
    rst_n = 1'b0; resp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    set0(6'b000001, 32'd1, 32'd2);
    set1(6'b000001, 32'd3, 32'd4);
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset_state");
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention straight after reset: grants 0,1,0,1.
    set0(6'b000001, 32'd1, 32'd2);
    set1(6'b000010, 32'd30, 32'd10);
    push(1'b0, 32'd3, 1'b0, 1'b0, 2);
    push(1'b1, 32'd20, 1'b0, 1'b0, 2);
    push(1'b0, 32'd3, 1'b0, 1'b0, 2);
    push(1'b1, 32'd20, 1'b0, 1'b0, 2);
    go(2'b11, 4);

    set0(6'b000001, 32'd5, 32'd7);          push(1'b0, 32'd12, 1'b0, 1'b0, 2); go(2'b01, 1);
    set1(6'b001001, 32'd6, 32'd7);          push(1'b1, 32'd42, 1'b0, 1'b0, 5); go(2'b10, 1);
    set0(6'b001010, 32'd9, 32'd0);          push(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 2); go(2'b01, 1);
    set1(6'b001011, 32'd9, 32'd0);          push(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 2); go(2'b10, 1);
    set0(6'b001010, 32'd100, 32'd7);        push(1'b0, 32'd14, 1'b0, 1'b0, 5); go(2'b01, 1);
    set1(6'b001011, 32'd100, 32'd7);        push(1'b1, 32'd2, 1'b0, 1'b0, 5); go(2'b10, 1);
    set0(6'b000010, 32'd5, 32'd5);          push(1'b0, 32'd0, 1'b1, 1'b0, 2); go(2'b01, 1);
    set1(6'b111111, 32'hF0F0, 32'h0FF0);    push(1'b1, 32'h0000_FF00, 1'b0, 1'b0, 2); go(2'b10, 1);

    // Backpressure: hold the response for 4 cycles with req1 asking meanwhile.
    resp_ready = 1'b0;
    set0(6'b000001, 32'd3, 32'd4);
    push(1'b0, 32'd7, 1'b0, 1'b0, 2);
    req0_valid = 1'b1;
    k = 0;
    while (!resp_valid && k < 50) begin
      @(posedge clk); #1; k++;
      if (busy) req0_valid = 1'b0;
    end
    chk("bp_resp_valid", 64'(resp_valid), 64'd1);
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold", {req0_ready, req1_ready, busy, resp_valid, resp_result},
          {1'b0, 1'b0, 1'b1, 1'b1, 32'd7});
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_after_accept", {busy, resp_valid}, 64'd0);

    // Reset in the middle of a multiply: no response, pointer back to 0.
    set1(6'b001001, 32'd6, 32'd7);
    r0 = resps;
    req1_valid = 1'b1;
    k = 0;
    while (!busy && k < 50) begin @(posedge clk); #1; k++; end
    req1_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1 check_reset_outputs("reset_mid_exec");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("no_resp_after_reset", 64'(resps - r0), 64'd0);
    set0(6'b000001, 32'd5, 32'd7);
    set1(6'b000001, 32'd100, 32'd100);
    push(1'b0, 32'd12, 1'b0, 1'b0, 2);
    go(2'b11, 1);

    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
